// File: rtl/legv8_cu_pkg.sv
// Shared encodings for the LEGv8 multicycle control unit: opcodes, ALU/PC codes,
// branch conditions, FSM states and control-word field layout.
package legv8_cu_pkg;

  localparam int CW_W      = 25;
  localparam int CW_SA     = 20;
  localparam int CW_SB     = 15;
  localparam int CW_DA     = 10;
  localparam int CW_RW     = 9;
  localparam int CW_MW     = 8;
  localparam int CW_FS     = 3;
  localparam int CW_BSEL   = 2;
  localparam int CW_EN_MEM = 1;
  localparam int CW_EN_ALU = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [7:0]  OP_BCND = 8'b01010100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_REG  = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic [CW_W-1:0] pack_cw(
    input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
    input logic rw, input logic mw, input logic [4:0] fs,
    input logic bsel, input logic en_mem, input logic en_alu);
    logic [CW_W-1:0] cw;
    cw                 = '0;
    cw[CW_SA +: 5]     = sa;
    cw[CW_SB +: 5]     = sb;
    cw[CW_DA +: 5]     = da;
    cw[CW_RW]          = rw;
    cw[CW_MW]          = mw;
    cw[CW_FS +: 5]     = fs;
    cw[CW_BSEL]        = bsel;
    cw[CW_EN_MEM]      = en_mem;
    cw[CW_EN_ALU]      = en_alu;
    return cw;
  endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// B.cond resolver: evaluates a 4-bit condition code against registered {V,C,N,Z}.
module legv8_cond_eval
  import legv8_cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic v, c, n, z;
  assign v = flags[3];
  assign c = flags[2];
  assign n = flags[1];
  assign z = flags[0];

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_HS: taken = c;
      COND_LO: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~(c & ~z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = ~(~z & (n == v));
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_control_fsm.sv
// LEGv8 multicycle control unit: FETCH -> EXEC -> (LDUR) MEM, decoding a latched IR.
// Optional HALT-on-zero-instruction behaviour and the halted port under LEGV8_CU_HALT_EN.
module legv8_control_fsm
  import legv8_cu_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32,
  parameter int XZR     = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [4:0]         status,
  output logic [CW_W-1:0]    control_word,
  output logic [DATA_W-1:0]  literal,
  output logic               SL,
  output logic [1:0]         PS
`ifdef LEGV8_CU_HALT_EN
  ,
  output logic               halted
`endif
);

  localparam logic [4:0] XZR_SEL = 5'(XZR);

  state_t             state;
  logic [INSTR_W-1:0] ir;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;
  logic [DATA_W-1:0] imm12_z, imm9_s, imm19_s, imm26_s;
  logic        cond_taken, cb_taken;

  assign op11 = ir[31:21];
  assign op10 = ir[31:22];
  assign op8  = ir[31:24];
  assign op6  = ir[31:26];
  assign rd   = ir[4:0];
  assign rn   = ir[9:5];
  assign rm   = ir[20:16];

  assign imm12_z = {{(DATA_W-12){1'b0}}, ir[21:10]};
  assign imm9_s  = {{(DATA_W-9){ir[20]}}, ir[20:12]};
  assign imm19_s = {{(DATA_W-19){ir[23]}}, ir[23:5]};
  assign imm26_s = {{(DATA_W-26){ir[25]}}, ir[25:0]};

  legv8_cond_eval u_cond_eval (
    .cond  (ir[3:0]),
    .flags (status[4:1]),
    .taken (cond_taken)
  );

  // CBZ/CBNZ resolve on the live ALU-zero flag of the EXEC cycle
  assign cb_taken = (op8 == OP_CBZ) ? status[0] : ~status[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= instruction;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
`ifdef LEGV8_CU_HALT_EN
          if (ir == '0)
            state <= ST_HALT;
          else
`endif
          if (op11 == OP_LDUR)
            state <= ST_MEM;
          else
            state <= ST_FETCH;
        end
        ST_MEM:  state <= ST_FETCH;
`ifdef LEGV8_CU_HALT_EN
        default: state <= ST_HALT;
`else
        default: state <= ST_FETCH;
`endif
      endcase
    end
  end

  logic [4:0]        sa, sb, da, fs;
  logic              rw, mw, bsel, en_mem, en_alu, sl_d, cw_zero;
  logic [1:0]        ps_d;
  logic [DATA_W-1:0] lit;

  always_comb begin
    sa = XZR_SEL; sb = XZR_SEL; da = XZR_SEL; fs = FS_AND;
    rw = 1'b0; mw = 1'b0; bsel = 1'b0; en_mem = 1'b0; en_alu = 1'b0;
    sl_d = 1'b0; cw_zero = 1'b1; ps_d = PS_HOLD; lit = '0;
    if (state == ST_EXEC || state == ST_MEM) begin
      cw_zero = 1'b0;
      ps_d    = PS_INC;
      if (op11 inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR}) begin
        sa = rn; sb = rm; da = rd; rw = 1'b1; en_alu = 1'b1;
        sl_d = (op11 == OP_ADDS) || (op11 == OP_SUBS);
        case (op11)
          OP_SUB, OP_SUBS: fs = FS_SUB;
          OP_AND:          fs = FS_AND;
          OP_ORR:          fs = FS_ORR;
          OP_EOR:          fs = FS_EOR;
          default:         fs = FS_ADD;
        endcase
      end else if (op11 == OP_LDUR) begin
        sa = rn; fs = FS_ADD; bsel = 1'b1; lit = imm9_s;
        if (state == ST_MEM) begin
          da = rd; rw = 1'b1; en_mem = 1'b1;
        end else begin
          ps_d = PS_HOLD;
        end
      end else if (op11 == OP_STUR) begin
        sa = rn; sb = rd; mw = 1'b1; fs = FS_ADD; bsel = 1'b1; lit = imm9_s;
      end else if (op11 == OP_BR) begin
        sa = rn; ps_d = PS_REG;
      end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
        sa = rn; da = rd; rw = 1'b1; en_alu = 1'b1; bsel = 1'b1; lit = imm12_z;
        fs = (op10 == OP_SUBI) ? FS_SUB : FS_ADD;
      end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
        sa = rd; fs = FS_ADD; lit = imm19_s;
        if (cb_taken) ps_d = PS_BR;
      end else if (op8 == OP_BCND) begin
        lit = imm19_s;
        if (cond_taken) ps_d = PS_BR;
      end else if (op6 == OP_B) begin
        lit = imm26_s; ps_d = PS_BR;
      end else begin
        cw_zero = 1'b1;
      end
`ifdef LEGV8_CU_HALT_EN
      if (state == ST_EXEC && ir == '0) ps_d = PS_HOLD;
`endif
    end
  end

  // Reset overrides everything so an aborted LDUR can never write back
  assign control_word = (reset || cw_zero) ? '0 :
                        pack_cw(sa, sb, da, rw && (da != XZR_SEL), mw, fs, bsel, en_mem, en_alu);
  assign literal      = reset ? '0 : lit;
  assign SL           = reset ? 1'b0 : sl_d;
  assign PS           = reset ? PS_HOLD : ps_d;
`ifdef LEGV8_CU_HALT_EN
  assign halted       = ~reset && (state == ST_HALT);
`endif

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Scoreboard bench for legv8_control_fsm: each beat carries stimulus and the expected outputs.
module tb_legv8_control_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [24:0] control_word;
  logic [63:0] literal;
  logic        SL;
  logic [1:0]  PS;
  logic        halted_obs;

`ifdef LEGV8_CU_HALT_EN
  logic halted;
  assign halted_obs = halted;
`else
  assign halted_obs = 1'b0;
`endif

  legv8_control_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .literal      (literal),
    .SL           (SL),
    .PS           (PS)
`ifdef LEGV8_CU_HALT_EN
    ,
    .halted       (halted)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic [4:0]  st;
    logic [24:0] cw;
    logic [63:0] lit;
    logic        sl;
    logic [1:0]  ps;
    logic        h;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  function automatic logic [24:0] cwf(input int sa, input int sb, input int da,
                                      input bit rw, input bit mw, input logic [4:0] fs,
                                      input bit bsel, input bit mem, input bit alu);
    return {5'(sa), 5'(sb), 5'(da), rw, mw, fs, bsel, mem, alu};
  endfunction

  function automatic void push(input string nm, input logic r, input logic [31:0] ins,
                               input logic [4:0] st, input logic [24:0] c, input logic [63:0] l,
                               input logic s, input logic [1:0] p, input logic h);
    beat_t b;
    b.name = nm; b.rst = r; b.instr = ins; b.st = st;
    b.cw = c; b.lit = l; b.sl = s; b.ps = p; b.h = h;
    sbq.push_back(b);
  endfunction

  // FETCH beat presents the instruction; EXEC beat drives junk so only the latched IR matters
  function automatic void push_instr(input string nm, input logic [31:0] ins, input logic [4:0] st,
                                     input logic [24:0] c, input logic [63:0] l,
                                     input logic s, input logic [1:0] p);
    push({nm, "_fetch"}, 1'b0, ins, st, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push({nm, "_exec"}, 1'b0, JUNK, st, c, l, s, p, 1'b0);
  endfunction

  task automatic test_reset();
    beat_t b;
    push("rst0", 1'b1, JUNK, 5'h1F, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push("rst1", 1'b1, JUNK, 5'h1F, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push_instr("ldur_pre", {11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd3}, 5'd0,
               cwf(4, 31, 31, 0, 0, 5'b01000, 1, 0, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 2'b00);
    push("rst_mem0", 1'b1, JUNK, 5'd0, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push("rst_mem1", 1'b1, JUNK, 5'd0, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push_instr("post_rst_addi", {10'b1001000100, 12'd5, 5'd2, 5'd1}, 5'd0,
               cwf(2, 31, 1, 1, 0, 5'b01000, 1, 0, 1), 64'd5, 1'b0, 2'b01);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_alu();
    beat_t b;
    push_instr("addi", {10'b1001000100, 12'd5, 5'd2, 5'd1}, 5'd0,
               cwf(2, 31, 1, 1, 0, 5'b01000, 1, 0, 1), 64'd5, 1'b0, 2'b01);
    push_instr("subi_zext", {10'b1101000100, 12'hFFF, 5'd12, 5'd13}, 5'd0,
               cwf(12, 31, 13, 1, 0, 5'b01001, 1, 0, 1), 64'h0000_0000_0000_0FFF, 1'b0, 2'b01);
    push_instr("add", {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd20}, 5'd0,
               cwf(1, 2, 20, 1, 0, 5'b01000, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    push_instr("adds", {11'b10101011000, 5'd3, 6'd0, 5'd4, 5'd5}, 5'd0,
               cwf(4, 3, 5, 1, 0, 5'b01000, 0, 0, 1), 64'd0, 1'b1, 2'b01);
    push_instr("and", {11'b10001010000, 5'd9, 6'd0, 5'd8, 5'd7}, 5'd0,
               cwf(8, 9, 7, 1, 0, 5'b00000, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    push_instr("orr", {11'b10101010000, 5'd9, 6'd0, 5'd8, 5'd7}, 5'd0,
               cwf(8, 9, 7, 1, 0, 5'b00100, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    push_instr("eor", {11'b11001010000, 5'd9, 6'd0, 5'd8, 5'd7}, 5'd0,
               cwf(8, 9, 7, 1, 0, 5'b01100, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    push_instr("sub", {11'b11001011000, 5'd9, 6'd0, 5'd8, 5'd7}, 5'd0,
               cwf(8, 9, 7, 1, 0, 5'b01001, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    push_instr("add_to_xzr", {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31}, 5'd0,
               cwf(1, 2, 31, 0, 0, 5'b01000, 0, 0, 1), 64'd0, 1'b0, 2'b01);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem();
    beat_t b;
    push_instr("ldur", {11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd3}, 5'd0,
               cwf(4, 31, 31, 0, 0, 5'b01000, 1, 0, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 2'b00);
    push("ldur_mem", 1'b0, JUNK, 5'd0, cwf(4, 31, 3, 1, 0, 5'b01000, 1, 1, 0),
         64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 2'b01, 1'b0);
    push_instr("stur", {11'b11111000000, 9'd16, 2'b00, 5'd11, 5'd10}, 5'd0,
               cwf(11, 10, 31, 0, 1, 5'b01000, 1, 0, 0), 64'd16, 1'b0, 2'b01);
    push_instr("ldur_xzr", {11'b11111000010, 9'd8, 2'b00, 5'd6, 5'd31}, 5'd0,
               cwf(6, 31, 31, 0, 0, 5'b01000, 1, 0, 0), 64'd8, 1'b0, 2'b00);
    push("ldur_xzr_mem", 1'b0, JUNK, 5'd0, cwf(6, 31, 31, 0, 0, 5'b01000, 1, 1, 0),
         64'd8, 1'b0, 2'b01, 1'b0);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    logic [24:0] br_cw;
    br_cw = cwf(31, 31, 31, 0, 0, 5'b00000, 0, 0, 0);
    push_instr("subs", {11'b11101011000, 5'd8, 6'd0, 5'd7, 5'd6}, 5'b01000,
               cwf(7, 8, 6, 1, 0, 5'b01001, 0, 0, 1), 64'd0, 1'b1, 2'b01);
    push_instr("bgt_taken", {8'b01010100, 19'd3, 1'b0, 4'b1100}, 5'b01000,
               br_cw, 64'd3, 1'b0, 2'b10);
    push_instr("bgt_z", {8'b01010100, 19'd3, 1'b0, 4'b1100}, 5'b01010,
               br_cw, 64'd3, 1'b0, 2'b01);
    push_instr("b_neg", {6'b000101, 26'h3FF_FFFF}, 5'd0,
               br_cw, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10);
    push_instr("br", {11'b11010110000, 5'd31, 6'd0, 5'd9, 5'd0}, 5'd0,
               cwf(9, 31, 31, 0, 0, 5'b00000, 0, 0, 0), 64'd0, 1'b0, 2'b11);
    push_instr("undef", JUNK, 5'd0, 25'd0, 64'd0, 1'b0, 2'b01);
`ifndef LEGV8_CU_HALT_EN
    push_instr("zero_nop", 32'd0, 5'd0, 25'd0, 64'd0, 1'b0, 2'b01);
`endif
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cbz();
    beat_t b;
    logic [24:0] cb_cw;
    cb_cw = cwf(5, 31, 31, 0, 0, 5'b01000, 0, 0, 0);
    push_instr("cbz_taken", {8'b10110100, 19'h7FFFC, 5'd5}, 5'b00001,
               cb_cw, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 2'b10);
    push_instr("cbz_not", {8'b10110100, 19'h7FFFC, 5'd5}, 5'b11110,
               cb_cw, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 2'b01);
    push_instr("cbnz_taken", {8'b10110101, 19'd40, 5'd5}, 5'b00000,
               cb_cw, 64'd40, 1'b0, 2'b10);
    push_instr("cbnz_not", {8'b10110101, 19'd40, 5'd5}, 5'b00001,
               cb_cw, 64'd40, 1'b0, 2'b01);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_cond_table();
    beat_t b;
    logic [3:0] conds [15];
    logic [4:0] stats [15];
    logic [1:0] pss   [15];
    // status = {V,C,N,Z,zero}
    conds = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
              4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
    stats = '{5'b00010, 5'b00010, 5'b01000, 5'b01000, 5'b00100, 5'b00100, 5'b10000, 5'b00000,
              5'b01010, 5'b01010, 5'b10100, 5'b00100, 5'b00010, 5'b00000, 5'b00000};
    pss   = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10,
              2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 15; i++)
      push_instr($sformatf("bcond_%0d", i), {8'b01010100, 19'd2, 1'b0, conds[i]}, stats[i],
                 cwf(31, 31, 31, 0, 0, 5'b00000, 0, 0, 0), 64'd2, 1'b0, pss[i]);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask

`ifdef LEGV8_CU_HALT_EN
  task automatic test_halt();
    beat_t b;
    push_instr("halt_enter", 32'd0, 5'd0, 25'd0, 64'd0, 1'b0, 2'b00);
    for (int i = 0; i < 12; i++)
      push($sformatf("halt_hold_%0d", i), 1'b0, {10'b1001000100, 12'd5, 5'd2, 5'd1}, 5'h1F,
           25'd0, 64'd0, 1'b0, 2'b00, 1'b1);
    push("halt_rst", 1'b1, JUNK, 5'd0, 25'd0, 64'd0, 1'b0, 2'b00, 1'b0);
    push_instr("halt_after_addi", {10'b1001000100, 12'd5, 5'd2, 5'd1}, 5'd0,
               cwf(2, 31, 1, 1, 0, 5'b01000, 1, 0, 1), 64'd5, 1'b0, 2'b01);
    while (sbq.size() > 0) begin
      b = sbq.pop_front();
      reset = b.rst; instruction = b.instr; status = b.st; #4;
      total++;
      if ({control_word, literal, SL, PS, halted_obs} !== {b.cw, b.lit, b.sl, b.ps, b.h}) begin
        bad++;
        $display("FAIL %s: got cw=%h lit=%h SL=%b PS=%b halted=%b, want cw=%h lit=%h SL=%b PS=%b halted=%b",
                 b.name, control_word, literal, SL, PS, halted_obs, b.cw, b.lit, b.sl, b.ps, b.h);
      end
      @(posedge clock); #1;
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    instruction = 32'd0;
    status = 5'd0;
    @(posedge clock); #1;
    test_reset();
    test_alu();
    test_mem();
    test_back_to_back();
    test_cbz();
    test_cond_table();
`ifdef LEGV8_CU_HALT_EN
    test_halt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/legv8_control_fsm.md
Name: legv8_control_fsm

Overview:
- Multicycle control unit that sits directly upstream of the LEGv8 datapath.
- Latches the fetched instruction into an internal IR and decodes it.
- Per state, drives the 25-bit datapath control word, the 64-bit literal/constant, the status-load strobe and the PC select.
- Consumes the datapath status flags to resolve conditional branches.

Parameters:
- DATA_W, 64, width of literal output.
- INSTR_W, 32, instruction width.
- XZR, 31, zero-register index used for unused register selects.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instruction  in  INSTR_W  instruction word from program ROM; valid during FETCH
- status  in  5  {V,C,N,Z} registered flags on [4:1]; [0] is live ALU-zero
- control_word  out  25  {SA[4:0],SB[4:0],DA[4:0],RegWrite,MemWrite,FS[4:0],Bsel,EN_Mem,EN_ALU}
- literal  out  DATA_W  sign/zero-extended immediate to datapath constant input
- SL  out  1  status-register load enable
- PS  out  2  PC select: 00 hold, 01 PC+4, 10 PC+(literal<<2), 11 PC=RegA

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clock and reset.
- Reset: state=FETCH, IR=0. While reset is high, all outputs are forced to 0, so no write, no PC change and no bus drive.
- Reset mid-instruction aborts it. Any pending LDUR write is dropped.
- States: FETCH -> EXEC -> (LDUR only) MEM -> FETCH.
  - FETCH: IR <= instruction at the clock edge. control_word=0. PS=00. SL=0.
  - EXEC: decode IR. The final cycle of each instruction drives PS=01, or the branch select when taken.
  - MEM (LDUR): same SA/Bsel/FS as EXEC, plus EN_Mem=1, RegWrite=1, DA=Rt, PS=01.
- Latency: R, I, STUR and branches take 2 cycles; LDUR takes 3.
- ALU FS encoding (FS[4:2] op, FS[1] invA, FS[0] invB+cin): AND 00000, ORR 00100, ADD 01000, SUB 01001, EOR 01100.
- R-type (ADD/ADDS/SUB/SUBS/AND/ORR/EOR): SA=Rn, SB=Rm, DA=Rd, Bsel=0, EN_ALU=1, RegWrite=1. SL=1 only for ADDS/SUBS.
- ADDI/SUBI: literal = zero-extended imm12 [21:10]. Bsel=1, EN_ALU=1, RegWrite=1.
- LDUR/STUR: literal = sign-extended imm9 [20:12]. FS=ADD, Bsel=1, SA=Rn.
  - STUR: SB=Rt, MemWrite=1 in EXEC, EN_ALU=0.
  - LDUR EXEC: all enables 0.
- B: literal = sign-extended imm26. PS=10.
- CBZ/CBNZ: literal = sign-extended imm19 [23:5]. SA=Rt, SB=XZR, Bsel=0, FS=ADD, EN_ALU=0. status[0] is evaluated in the same cycle. Taken -> PS=10, else PS=01.
- B.cond: literal = imm19. cond=IR[3:0], evaluated on status[4:1]:
  - EQ/NE on Z; HS/LO on C; MI/PL on N; VS/VC on V.
  - HI = C&!Z; LS = its inverse.
  - GE = N==V; LT = its inverse.
  - GT = !Z&(N==V); LE = its inverse.
  - 1110/1111 = always taken.
- BR: SA=Rn, PS=11.
- Unused register selects = XZR.
- Undefined opcode: NOP, meaning control_word=0 and PS=01.
- RegWrite is never asserted with DA=XZR.

Optional Feature:
- Macro: LEGV8_CU_HALT_EN.
- Defined: IR==32'h0000_0000 in EXEC enters HALT. HALT holds PS=00, control_word=0 and SL=0 until reset. An extra output port, halted (1 bit), is 1 in HALT.
- Undefined: all-zero instruction is an undefined-opcode NOP. There is no HALT state and no halted port.

Decomposition:
- Package legv8_cu_pkg holds:
  - opcode constants
  - FS codes
  - PS codes
  - cond codes
  - state enum
  - control-word field offsets
- Sub-module legv8_cond_eval (combinational): inputs cond[3:0] and flags[3:0]; output taken.

Test Plan:
- Reset high for 2 cycles mid-LDUR MEM state -> control_word=0, PS=00; next cycle is FETCH; Rt unwritten.
- ADDI X1,X2,#5 -> EXEC: SA=2, DA=1, Bsel=1, FS=01000, literal=5, RegWrite=1, EN_ALU=1, PS=01; 2 cycles total.
- LDUR X3,[X4,#-8] -> literal=64'hFFFF_FFFF_FFFF_FFF8. EXEC has enables 0. MEM has EN_Mem=1, RegWrite=1, DA=3, PS=01.
- SUBS then B.GT with status[4:1]={V=0,C=1,N=0,Z=0} -> SL=1 on SUBS; B.GT PS=10. Z=1 -> PS=01.
- CBZ X5 with status[0]=1 -> PS=10, literal = sign-extended imm19. With status[0]=0 -> PS=01.
- With LEGV8_CU_HALT_EN defined, instruction 0 -> halted=1, PS=00 for 10+ cycles. Reset clears halted.
